// File: rtl/branch_pred_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_pred_ctrl_pkg
// Shared definitions for the conditional-branch predictor/controller:
//   - 2-bit saturating counter encodings
//   - controller state enum
//   - saturating counter update helper
// ---------------------------------------------------------------------------
package branch_pred_ctrl_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken (reset value)
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        FLUSH    = 2'b10
    } state_e;

    // Move the counter one step toward the observed outcome, clamping at
    // the strong ends so a single odd outcome cannot flip a strong bias.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr,
                                              input logic       taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_bht.sv
// ---------------------------------------------------------------------------
// branch_hist_table
// Array of 2-bit saturating direction counters.
//   clk, rst      : clock, asynchronous active-high reset (all counters -> WNT)
//   rd_idx/rd_ctr : combinational read port (fetch lookup)
//   upd_en/upd_idx/upd_taken : clocked training port (EX resolve)
// A read of the entry being updated in the same cycle returns the old value.
// ---------------------------------------------------------------------------
module branch_hist_table
    import branch_pred_ctrl_pkg::*;
#(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            ctr_d[upd_idx] = ctr_update(ctr_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // Reads the registered array directly: no bypass from the update port.
    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// ---------------------------------------------------------------------------
// branch_pred_ctrl
// Conditional-branch predictor and mispredict sequencer for the RV32 pipeline.
//   Fetch side : f_valid, f_is_branch, f_pc, f_imm -> pred_taken, pred_target
//   EX side    : ex_valid, ex_pc, ex_target, ex_pred_taken, bSel
//   Recovery   : redirect (1 cycle), redirect_pc, flush (FLUSH_CYCLES cycles)
//   Statistics : br_count, mispred_count (wrap at 2^32)
// clk rising edge; rst asynchronous active-high clears all state.
// ---------------------------------------------------------------------------
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_valid,
    input  logic            f_is_branch,
    input  logic [XLEN-1:0] f_pc,
    input  logic [XLEN-1:0] f_imm,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic            bSel,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    // Wide enough to hold FLUSH_CYCLES and the constant 2 even when FLUSH_CYCLES=1.
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;      // flush-high cycles so far, incl. current
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mispred_count_q, mispred_count_d;

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       f_ctr;
    logic             accept;
    logic             mispredict;

    // Word-aligned PCs: skip the two always-zero low bits.
    assign f_idx  = f_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Resolves arriving while recovering are wrong-path and must not train.
    assign accept     = ex_valid && (state_q == IDLE);
    assign mispredict = (bSel != ex_pred_taken);

    branch_hist_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (f_idx),
        .rd_ctr    (f_ctr),
        .upd_en    (accept),
        .upd_idx   (ex_idx),
        .upd_taken (bSel)
    );

    assign pred_taken  = f_valid & f_is_branch & f_ctr[1];
    assign pred_target = f_pc + f_imm;

    always_comb begin
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        redirect_pc_d   = redirect_pc_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        redirect        = 1'b0;
        flush           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    br_count_d = br_count_q + 32'd1;
                    if (mispredict) begin
                        state_d         = REDIRECT;
                        fcnt_d          = CNT_W'(1);
                        redirect_pc_d   = bSel ? ex_target : (ex_pc + XLEN'(4));
                        mispred_count_d = mispred_count_q + 32'd1;
                    end
                end
            end
            REDIRECT: begin
                redirect = 1'b1;
                flush    = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    fcnt_d  = CNT_W'(2);
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (fcnt_q >= FLUSH_LAST) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            fcnt_q          <= '0;
            redirect_pc_q   <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            state_q         <= state_d;
            fcnt_q          <= fcnt_d;
            redirect_pc_q   <= redirect_pc_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign redirect_pc   = redirect_pc_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule
